// File: rtl/imm_gen_pkg.sv
// Shared encodings and result type for the registered immediate generator.
package imm_gen_pkg;

  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_S    = 3'd1;
  localparam logic [2:0] FMT_B    = 3'd2;
  localparam logic [2:0] FMT_U    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_ZIMM = 3'd5;
  localparam logic [2:0] FMT_ILL  = 3'd6;
  localparam logic [2:0] SEL_AUTO = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // imm is the 32-bit sign-extended form; bit 31 is the sign for wider results.
  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } imm_res_t;

  function automatic logic [2:0] auto_fmt(input logic [31:0] instr);
    logic [2:0] f;
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: f = FMT_I;
      OP_STORE:                           f = FMT_S;
      OP_BRANCH:                          f = FMT_B;
      OP_LUI, OP_AUIPC:                   f = FMT_U;
      OP_JAL:                             f = FMT_J;
      OP_SYSTEM:                          f = instr[14] ? FMT_ZIMM : FMT_I;
      default:                            f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction for one instruction, including opcode-based
// format selection.
module imm_extract
  import imm_gen_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [2:0]  imm_sel,
  output imm_res_t    res
);

  logic [2:0] fmt;

  always_comb begin
    fmt = (imm_sel == SEL_AUTO) ? auto_fmt(instr) : imm_sel;
    res = '0;
    res.fmt = fmt;
    res.illegal = (fmt == FMT_ILL);
    case (fmt)
      FMT_I:    res.imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:    res.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:    res.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
      FMT_U:    res.imm = {instr[31:12], 12'b0};
      FMT_J:    res.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
      FMT_ZIMM: res.imm = {27'b0, instr[19:15]};
      default:  res.imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: extraction feeding an output register plus a
// single skid entry, with a saturating count of consumed illegal results.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  imm_res_t         res;
  imm_res_t         out_q;
  imm_res_t         skid_q;
  logic             out_valid_q;
  logic             skid_valid_q;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             skid_fill;

  imm_extract u_extract (
    .instr   (instr),
    .imm_sel (imm_sel),
    .res     (res)
  );

  assign in_xfer  = in_valid && ready_q;
  assign out_xfer = out_valid_q && out_ready;
  // Skid holds (or captures) an entry only while the output register is stuck.
  assign skid_fill = out_valid_q && !out_ready && (skid_valid_q || in_xfer);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (out_xfer && out_q.illegal && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (!out_valid_q || out_ready) begin
        if (skid_valid_q) begin
          out_q       <= skid_q;
          out_valid_q <= 1'b1;
        end else if (in_xfer) begin
          out_q       <= res;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_q <= res;
      end
      skid_valid_q <= skid_fill;
      ready_q      <= !skid_fill;
    end
  end

  generate
    if (XLEN == 64) begin : g_ext64
      assign imm = {{32{out_q.imm[31]}}, out_q.imm};
    end else begin : g_ext32
      assign imm = out_q.imm;
    end
  endgenerate

  assign in_ready    = ready_q;
  assign out_valid   = out_valid_q;
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: two instances (XLEN=32/CNT_W=16 and XLEN=64/CNT_W=2)
// share one stimulus stream and are checked against a transaction-level model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_sel;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, ill_a;
  logic [31:0] imm_a;
  logic [2:0]  fmt_a;
  logic [15:0] cnt_a;
  logic        in_ready_b, out_valid_b, ill_b;
  logic [63:0] imm_b;
  logic [2:0]  fmt_b;
  logic [1:0]  cnt_b;

  int checks = 0;
  int passes = 0;

  // Model: results in FIFO order as {imm64, fmt, illegal}.
  logic [67:0] exp_q[$];
  logic        last_rst = 1'b1;
  int          exp_cnt_a = 0;
  int          exp_cnt_b = 0;
  logic        accepted;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .instr(instr), .imm_sel(imm_sel), .out_valid(out_valid_a), .out_ready(out_ready),
    .imm(imm_a), .out_fmt(fmt_a), .out_illegal(ill_a), .illegal_cnt(cnt_a)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .instr(instr), .imm_sel(imm_sel), .out_valid(out_valid_b), .out_ready(out_ready),
    .imm(imm_b), .out_fmt(fmt_b), .out_illegal(ill_b), .illegal_cnt(cnt_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [67:0] ref_res(input logic [31:0] i, input logic [2:0] s);
    logic [2:0] f;
    longint     v;
    f = s;
    if (s == 3'd7) begin
      case (i[6:0])
        7'h03, 7'h13, 7'h1B, 7'h67: f = 3'd0;
        7'h23:                      f = 3'd1;
        7'h63:                      f = 3'd2;
        7'h37, 7'h17:               f = 3'd3;
        7'h6F:                      f = 3'd4;
        7'h73:                      f = i[14] ? 3'd5 : 3'd0;
        default:                    f = 3'd6;
      endcase
    end
    case (f)
      3'd0: v = longint'($signed(i[31:20]));
      3'd1: v = longint'($signed({i[31:25], i[11:7]}));
      3'd2: v = longint'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
      3'd3: v = longint'($signed(i[31:12])) * 4096;
      3'd4: v = longint'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
      3'd5: v = longint'(i[19:15]);
      default: v = 0;
    endcase
    return {v, f, f == 3'd6};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops[10];
    logic [31:0] w;
    ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};
    w = $urandom;
    if ($urandom_range(0, 3) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    logic        exp_in_ready, exp_out_valid, in_x, out_x;
    logic [67:0] e;
    @(negedge clk);
    exp_out_valid = exp_q.size() > 0;
    exp_in_ready  = !last_rst && (exp_q.size() < 2);
    chk("in_ready_a", in_ready_a, exp_in_ready);
    chk("in_ready_b", in_ready_b, exp_in_ready);
    chk("out_valid_a", out_valid_a, exp_out_valid);
    chk("out_valid_b", out_valid_b, exp_out_valid);
    chk("cnt_a", cnt_a, exp_cnt_a);
    chk("cnt_b", cnt_b, exp_cnt_b);
    in_x  = rst_n && in_valid && exp_in_ready;
    out_x = rst_n && out_ready && exp_out_valid;
    if (out_x) begin
      e = exp_q.pop_front();
      chk("imm_a", imm_a, e[35:4]);
      chk("imm_b", imm_b, e[67:4]);
      chk("fmt_a", fmt_a, e[3:1]);
      chk("fmt_b", fmt_b, e[3:1]);
      chk("ill_a", ill_a, e[0]);
      chk("ill_b", ill_b, e[0]);
      if (e[0]) begin
        if (exp_cnt_a < 65535) exp_cnt_a++;
        if (exp_cnt_b < 3) exp_cnt_b++;
      end
    end
    accepted = in_x;
    if (in_x) exp_q.push_back(ref_res(instr, imm_sel));
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt_a = 0;
      exp_cnt_b = 0;
      last_rst  = 1'b1;
    end else begin
      last_rst = 1'b0;
    end
    #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [2:0] s);
    instr    = i;
    imm_sel  = s;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();
  endtask

  initial begin
    int n_acc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0; imm_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_imm", imm_a, 0);
    chk("rst_fmt", fmt_a, 0);
    chk("rst_ill", ill_a, 0);
    chk("rst_cnt", cnt_a, 0);
    chk("rst_in_ready", in_ready_a, 0);
    rst_n = 1'b1;
    cycle();
    chk("in_ready_after_release", in_ready_a, 1);

    // Directed formats with the consumer always ready.
    out_ready = 1'b1;
    send(32'hFFF00093, 3'd0);
    chk("i_lat_valid", out_valid_a, 1);
    chk("i_imm", imm_a, 32'hFFFFFFFF);
    chk("i_fmt", fmt_a, 0);
    send(32'hFF9FF06F, 3'd7);
    chk("j_imm", imm_a, 32'hFFFFFFF8);
    chk("j_fmt", fmt_a, 4);
    send(32'hFE20AE23, 3'd7);
    chk("s_imm", imm_a, 32'hFFFFFFFC);
    chk("s_fmt", fmt_a, 1);
    send(32'h123452B7, 3'd7);
    chk("u_imm", imm_a, 32'h12345000);
    chk("u_imm64", imm_b, 64'h0000000012345000);
    send(32'h800002B7, 3'd7);
    chk("u_imm64_neg", imm_b, 64'hFFFFFFFF80000000);
    send(32'h0000007F, 3'd7);
    chk("ill_imm", imm_a, 0);
    chk("ill_fmt", fmt_a, 6);
    chk("ill_flag", ill_a, 1);
    chk("ill_cnt_before", cnt_a, 0);
    cycle();
    chk("ill_cnt_after", cnt_a, 1);
    send(32'h300FD073, 3'd7);
    chk("zimm_imm", imm_a, 32'h1F);
    chk("zimm_fmt", fmt_a, 5);
    send(32'h300F9073, 3'd7);
    chk("csr_i_imm", imm_a, 32'h300);
    chk("csr_i_fmt", fmt_a, 0);
    send(32'hFFF00093, 3'd6);
    chk("sel6_fmt", fmt_a, 6);
    send(32'h0000000B, 3'd7);
    send(32'hFFFFFFFF, 3'd7);
    send(32'h12345678, 3'd6);
    cycle();
    chk("ill_cnt_5", cnt_a, 5);
    chk("ill_cnt_sat", cnt_b, 3);

    // Backpressure: four AUTO instructions, consumer stalled for four cycles.
    out_ready = 1'b0;
    n_acc = 0;
    instr = rand_instr(); imm_sel = 3'd7; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (accepted) begin n_acc++; instr = rand_instr(); end
      if (k == 1) chk("bp_in_ready_low", in_ready_a, 0);
    end
    chk("bp_accepts_stalled", n_acc, 2);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && n_acc < 4; k++) begin
      cycle();
      if (accepted) begin n_acc++; instr = rand_instr(); end
    end
    chk("bp_accepts_total", n_acc, 4);
    for (int k = 0; k < 8; k++) begin
      instr = rand_instr();
      cycle();
      chk("full_rate_accept", accepted, 1);
    end
    drain();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      instr     = rand_instr();
      imm_sel   = ($urandom_range(0, 1) != 0) ? 3'd7 : 3'($urandom_range(0, 6));
      cycle();
    end
    drain();

    // Reset with two entries buffered.
    out_ready = 1'b0;
    imm_sel = 3'd7;
    send(rand_instr(), 3'd7);
    send(rand_instr(), 3'd7);
    chk("pre_rst_in_ready", in_ready_a, 0);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_out_valid", out_valid_a, 0);
    chk("mid_rst_cnt", cnt_a, 0);
    chk("mid_rst_cnt_b", cnt_b, 0);
    rst_n = 1'b1;
    cycle();
    chk("post_rst_in_ready", in_ready_a, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      in_valid = ($urandom_range(0, 1) != 0);
      instr    = rand_instr();
      cycle();
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
